ipsxe_floating_point_axi_result_buffer_v1_0: RTL

Output-side result collector for the floating-point cores. It sits between a fixed-latency core result pipeline, which cannot be stalled, and a downstream AXI-stream slave. It stores results in a small FIFO and presents them with valid/ready handshaking. It returns an issue credit to the input-side buffer so that no more operands enter the core than can be absorbed, which makes downstream backpressure lossless.

---
 rtl/ipsxe_floating_point_axi_result_buffer_v1_0_pkg.sv | 23 ++
 rtl/ipsxe_floating_point_sram_dualports_v1_0.sv | 28 ++
 rtl/ipsxe_floating_point_axi_result_buffer_v1_0.sv | 103 ++++++++++
 3 files changed

// File: rtl/ipsxe_floating_point_axi_result_buffer_v1_0_pkg.sv
// Shared constants for the floating-point result/issue buffers, so the input
// and output sides agree on the credit limit and error encoding.
package ipsxe_floating_point_axi_result_buffer_v1_0_pkg;

  localparam int RB_DATA_WIDTH = 32;
  localparam int RB_MEM_DEPTH  = 8;
  localparam int RB_CNT_WIDTH  = 9;

  typedef enum logic [1:0] {
    RB_ERR_NONE     = 2'd0,
    RB_ERR_OVERFLOW = 2'd1
  } rb_err_e;

  // Smallest counter width that can hold the value MEM_DEPTH itself.
  function automatic int rb_min_cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int rb_addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ipsxe_floating_point_sram_dualports_v1_0.sv
// Simple dual-port RAM, registered read. Read-during-write to the same address
// returns the new data so a freshly written FIFO head is visible next cycle.
module ipsxe_floating_point_sram_dualports_v1_0 #(
  parameter int MEM_WIDTH  = 32,
  parameter int MEM_DEPTH  = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [MEM_WIDTH-1:0]  wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [MEM_WIDTH-1:0]  rd_data_o
);

  logic [MEM_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [MEM_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i)
      rd_data_q <= (wr_en_i && (wr_addr_i == rd_addr_i)) ? wr_data_i : mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ipsxe_floating_point_axi_result_buffer_v1_0.sv
// Output-side result collector: absorbs an unstallable core result stream into a
// FIFO, presents it as AXI-stream, and hands issue credits back to the input side.
module ipsxe_floating_point_axi_result_buffer_v1_0
  import ipsxe_floating_point_axi_result_buffer_v1_0_pkg::*;
#(
  parameter int DATA_WIDTH = RB_DATA_WIDTH,
  parameter int MEM_DEPTH  = RB_MEM_DEPTH,
  parameter int CNT_WIDTH  = RB_CNT_WIDTH
) (
  input  logic                  i_aclk,
  input  logic                  i_areset,
  input  logic                  i_issue_valid,
  output logic                  o_issue_ready,
  input  logic                  i_res_valid,
  input  logic [DATA_WIDTH-1:0] i_res_data,
  output logic                  o_m_tvalid,
  output logic [DATA_WIDTH-1:0] o_m_tdata,
  input  logic                  i_m_tready,
  output logic                  o_overflow
);

  localparam int                   AW      = rb_addr_width(MEM_DEPTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(MEM_DEPTH);
  localparam logic [AW-1:0]        LAST_C  = AW'(MEM_DEPTH - 1);

  logic [CNT_WIDTH-1:0]  used_q, used_d, cnt_q, cnt_d;
  logic [AW-1:0]         wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic                  issue_ready_q, tvalid_q, tvalid_d, ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d, head;
  logic                  issue, pop, mem_ne, load, bypass, wr_en, rd_en, drop;

  always_comb begin
    issue  = i_issue_valid & issue_ready_q;
    pop    = tvalid_q & i_m_tready;
    mem_ne = (cnt_q != '0);
    load   = (!tvalid_q | i_m_tready) & (mem_ne | i_res_valid);
    bypass = load & !mem_ne;
    rd_en  = load & mem_ne;
    drop   = i_res_valid & !bypass & (cnt_q == DEPTH_C);
    wr_en  = i_res_valid & !bypass & !drop;

    used_d = used_q;
    if (issue && !pop)      used_d = used_q + 1'b1;
    else if (!issue && pop) used_d = used_q - 1'b1;

    cnt_d = cnt_q;
    if (wr_en && !rd_en)      cnt_d = cnt_q + 1'b1;
    else if (!wr_en && rd_en) cnt_d = cnt_q - 1'b1;

    wr_addr_d = wr_addr_q;
    if (wr_en) wr_addr_d = (wr_addr_q == LAST_C) ? '0 : wr_addr_q + 1'b1;
    rd_addr_d = rd_addr_q;
    if (rd_en) rd_addr_d = (rd_addr_q == LAST_C) ? '0 : rd_addr_q + 1'b1;

    tvalid_d = load | (tvalid_q & !pop);
    tdata_d  = load ? (mem_ne ? head : i_res_data) : tdata_q;
    ovf_d    = ovf_q | drop;
  end

  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      used_q        <= '0;
      cnt_q         <= '0;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      issue_ready_q <= 1'b0;
      tvalid_q      <= 1'b0;
      tdata_q       <= '0;
      ovf_q         <= 1'b0;
    end else begin
      used_q        <= used_d;
      cnt_q         <= cnt_d;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      issue_ready_q <= (used_d < DEPTH_C);
      tvalid_q      <= tvalid_d;
      tdata_q       <= tdata_d;
      ovf_q         <= ovf_d;
    end
  end

  // Reading at the next-state pointer every cycle keeps the head prefetched,
  // so a load from memory never waits on the RAM's registered read.
  ipsxe_floating_point_sram_dualports_v1_0 #(
    .MEM_WIDTH (DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_WIDTH(AW)
  ) u_mem (
    .clk_i    (i_aclk),
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_addr_q),
    .wr_data_i(i_res_data),
    .rd_en_i  (1'b1),
    .rd_addr_i(rd_addr_d),
    .rd_data_o(head)
  );

  assign o_issue_ready = issue_ready_q;
  assign o_m_tvalid    = tvalid_q;
  assign o_m_tdata     = tdata_q;
  assign o_overflow    = ovf_q;

endmodule
